// File: rtl/bsg_axil_fifo_responder_if.sv
// Bus bundle for bsg_axil_fifo_responder: AXI-lite write/read channels plus RX/TX word streams.
// The slave modport is the responder's view; master is the view of whatever drives it.
interface bsg_axil_fifo_responder_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
);
    logic                      awvalid_i;
    logic [addr_width_p-1:0]   awaddr_i;
    logic                      awready_o;
    logic                      wvalid_i;
    logic [data_width_p-1:0]   wdata_i;
    logic [data_width_p/8-1:0] wstrb_i;
    logic                      wready_o;
    logic                      bvalid_o;
    logic [1:0]                bresp_o;
    logic                      bready_i;

    logic                      arvalid_i;
    logic [addr_width_p-1:0]   araddr_i;
    logic                      arready_o;
    logic                      rvalid_o;
    logic [data_width_p-1:0]   rdata_o;
    logic [1:0]                rresp_o;
    logic                      rready_i;

    logic                      rx_v_i;
    logic [data_width_p-1:0]   rx_data_i;
    logic                      rx_ready_o;

    logic                      tx_v_o;
    logic [data_width_p-1:0]   tx_data_o;
    logic                      tx_yumi_i;

    modport slave (
        input  awvalid_i, awaddr_i, wvalid_i, wdata_i, wstrb_i, bready_i,
        output awready_o, wready_o, bvalid_o, bresp_o,
        input  arvalid_i, araddr_i, rready_i,
        output arready_o, rvalid_o, rdata_o, rresp_o,
        input  rx_v_i, rx_data_i,
        output rx_ready_o,
        input  tx_yumi_i,
        output tx_v_o, tx_data_o
    );

    modport master (
        output awvalid_i, awaddr_i, wvalid_i, wdata_i, wstrb_i, bready_i,
        input  awready_o, wready_o, bvalid_o, bresp_o,
        output arvalid_i, araddr_i, rready_i,
        input  arready_o, rvalid_o, rdata_o, rresp_o,
        output rx_v_i, rx_data_i,
        input  rx_ready_o,
        output tx_yumi_i,
        input  tx_v_o, tx_data_o
    );
endinterface

// File: rtl/bsg_axil_fifo_responder.sv
// AXI-lite register window onto an RX FIFO (stream in, popped by reads) and a TX FIFO
// (pushed by writes, drained by the tx stream). One write and one read outstanding at a time.
module bsg_axil_fifo_responder #(
    parameter int axil_addr_width_p = 32,
    parameter int axil_data_width_p = 32,
    parameter int fifo_els_p        = 16,
    parameter logic [axil_addr_width_p-1:0] base_addr_p = 'h1000
) (
    input logic clk_i,
    input logic reset_n_i,
    bsg_axil_fifo_responder_if.slave bus
);
    localparam int ptr_w = $clog2(fifo_els_p);
    localparam int cnt_w = ptr_w + 1;
    localparam logic [cnt_w-1:0] els_c = cnt_w'(fifo_els_p);

    localparam logic [axil_addr_width_p-1:0] off_tx_push = '0;
    localparam logic [axil_addr_width_p-1:0] off_tx_vac  = axil_addr_width_p'(32'h10);
    localparam logic [axil_addr_width_p-1:0] off_rx_cnt  = axil_addr_width_p'(32'h18);
    localparam logic [axil_addr_width_p-1:0] off_rx_pop  = axil_addr_width_p'(32'h1C);

    localparam logic [1:0] resp_okay   = 2'b00;
    localparam logic [1:0] resp_slverr = 2'b10;
    localparam logic [1:0] resp_decerr = 2'b11;

    logic unused_wstrb;
    assign unused_wstrb = ^bus.wstrb_i;

    // ---------------- RX FIFO ----------------
    logic [axil_data_width_p-1:0] rx_mem [fifo_els_p];
    logic [ptr_w-1:0]             rx_wptr, rx_rptr;
    logic [cnt_w-1:0]             rx_count;
    logic                         rx_full, rx_empty, rx_push, rx_pop;

    assign rx_full        = (rx_count == els_c);
    assign rx_empty       = (rx_count == '0);
    assign bus.rx_ready_o = !rx_full;
    assign rx_push        = bus.rx_v_i & !rx_full;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            rx_count <= rx_count + cnt_w'(rx_push) - cnt_w'(rx_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wptr] <= bus.rx_data_i;
    end

    // ---------------- TX FIFO ----------------
    logic [axil_data_width_p-1:0] tx_mem [fifo_els_p];
    logic [ptr_w-1:0]             tx_wptr, tx_rptr;
    logic [cnt_w-1:0]             tx_count;
    logic                         tx_full, tx_empty, tx_push, tx_pop;
    logic [axil_data_width_p-1:0] tx_push_data;

    assign tx_full       = (tx_count == els_c);
    assign tx_empty      = (tx_count == '0);
    assign bus.tx_v_o    = !tx_empty;
    assign bus.tx_data_o = tx_mem[tx_rptr];
    assign tx_pop        = bus.tx_yumi_i & !tx_empty;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            tx_count <= tx_count + cnt_w'(tx_push) - cnt_w'(tx_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wptr] <= tx_push_data;
    end

    // ---------------- write path ----------------
    logic                         aw_held, w_held, bvalid_r;
    logic [axil_addr_width_p-1:0] aw_addr_r, wr_addr, wr_off;
    logic [axil_data_width_p-1:0] w_data_r;
    logic [1:0]                   bresp_r, wr_resp;
    logic                         aw_fire, w_fire, wr_commit, wr_is_tx;

    assign bus.awready_o = !aw_held & !bvalid_r;
    assign bus.wready_o  = !w_held & !bvalid_r;
    assign bus.bvalid_o  = bvalid_r;
    assign bus.bresp_o   = bresp_r;

    assign aw_fire      = bus.awvalid_i & bus.awready_o;
    assign w_fire       = bus.wvalid_i & bus.wready_o;
    assign wr_commit    = (aw_held | aw_fire) & (w_held | w_fire) & !bvalid_r;
    assign wr_addr      = aw_held ? aw_addr_r : bus.awaddr_i;
    assign tx_push_data = w_held ? w_data_r : bus.wdata_i;
    assign wr_off       = wr_addr - base_addr_p;
    assign wr_is_tx     = (wr_off == off_tx_push);

    // Fullness is judged before any same-cycle tx pop, so a full FIFO always refuses.
    assign tx_push = wr_commit & wr_is_tx & !tx_full;

    always_comb begin
        wr_resp = resp_okay;
        if (!wr_is_tx)    wr_resp = resp_decerr;
        else if (tx_full) wr_resp = resp_slverr;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_r <= '0;
            w_data_r  <= '0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
        end else if (wr_commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_r <= 1'b1;
            bresp_r  <= wr_resp;
        end else begin
            if (aw_fire) begin
                aw_held   <= 1'b1;
                aw_addr_r <= bus.awaddr_i;
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_r <= bus.wdata_i;
            end
            if (bvalid_r & bus.bready_i) bvalid_r <= 1'b0;
        end
    end

    // ---------------- read path ----------------
    logic                         rvalid_r, ar_fire;
    logic [axil_data_width_p-1:0] rdata_r, rd_data;
    logic [1:0]                   rresp_r, rd_resp;
    logic [axil_addr_width_p-1:0] rd_off;

    assign bus.arready_o = !rvalid_r;
    assign bus.rvalid_o  = rvalid_r;
    assign bus.rdata_o   = rdata_r;
    assign bus.rresp_o   = rresp_r;

    assign ar_fire = bus.arvalid_i & !rvalid_r;
    assign rd_off  = bus.araddr_i - base_addr_p;

    // Counts are sampled before this cycle's push/pop takes effect.
    always_comb begin
        rd_data = '0;
        rd_resp = resp_decerr;
        rx_pop  = 1'b0;
        if (rd_off == off_tx_vac) begin
            rd_data[cnt_w-1:0] = els_c - tx_count;
            rd_resp            = resp_okay;
        end else if (rd_off == off_rx_cnt) begin
            rd_data[cnt_w-1:0] = rx_count;
            rd_resp            = resp_okay;
        end else if (rd_off == off_rx_pop) begin
            if (!rx_empty) begin
                rd_data = rx_mem[rx_rptr];
                rd_resp = resp_okay;
                rx_pop  = ar_fire;
            end else begin
                rd_resp = resp_slverr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
            rresp_r  <= 2'b00;
        end else if (ar_fire) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data;
            rresp_r  <= rd_resp;
        end else if (rvalid_r & bus.rready_i) begin
            rvalid_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bsg_axil_fifo_responder.sv
// Directed bench for bsg_axil_fifo_responder: register decode, FIFO ordering, full/empty edges.
module tb_bsg_axil_fifo_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bsg_axil_fifo_responder_if #(.addr_width_p(32), .data_width_p(32)) bus ();

    bsg_axil_fifo_responder #(
        .axil_addr_width_p(32),
        .axil_data_width_p(32),
        .fifo_els_p(16),
        .base_addr_p(32'h1000)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .bus(bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic axil_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.awaddr_i  = a;
        bus.awvalid_i = 1'b1;
        bus.wdata_i   = d;
        bus.wvalid_i  = 1'b1;
        n = 0;
        while ((bus.awvalid_i || bus.wvalid_i) && n < 20) begin
            logic a_acc, w_acc;
            a_acc = bus.awvalid_i & bus.awready_o;
            w_acc = bus.wvalid_i & bus.wready_o;
            @(negedge clk);
            if (a_acc) bus.awvalid_i = 1'b0;
            if (w_acc) bus.wvalid_i = 1'b0;
            n++;
        end
        bus.awvalid_i = 1'b0;
        bus.wvalid_i  = 1'b0;
        n = 0;
        while (!bus.bvalid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("wr_bvalid", 32'(bus.bvalid_o), 32'd1);
        resp = bus.bresp_o;
        @(negedge clk);
    endtask

    task automatic axil_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.araddr_i  = a;
        bus.arvalid_i = 1'b1;
        n = 0;
        while (!bus.arready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.arvalid_i = 1'b0;
        n = 0;
        while (!bus.rvalid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rd_rvalid", 32'(bus.rvalid_o), 32'd1);
        d    = bus.rdata_o;
        resp = bus.rresp_o;
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic [31:0] rx_vec [3];

    initial begin
        bus.awvalid_i = 1'b0; bus.awaddr_i = '0; bus.wvalid_i = 1'b0; bus.wdata_i = '0;
        bus.wstrb_i = '0; bus.bready_i = 1'b1;
        bus.arvalid_i = 1'b0; bus.araddr_i = '0; bus.rready_i = 1'b1;
        bus.rx_v_i = 1'b0; bus.rx_data_i = '0; bus.tx_yumi_i = 1'b0;
        rx_vec[0] = 32'hA0A0_0001; rx_vec[1] = 32'hB0B0_0002; rx_vec[2] = 32'hC0C0_0003;

        // reset values
        repeat (3) @(negedge clk);
        check_eq("rst_awready", 32'(bus.awready_o), 32'd1);
        check_eq("rst_wready",  32'(bus.wready_o),  32'd1);
        check_eq("rst_arready", 32'(bus.arready_o), 32'd1);
        check_eq("rst_rx_ready", 32'(bus.rx_ready_o), 32'd1);
        check_eq("rst_tx_v",    32'(bus.tx_v_o),    32'd0);
        check_eq("rst_bvalid",  32'(bus.bvalid_o),  32'd0);
        check_eq("rst_rvalid",  32'(bus.rvalid_o),  32'd0);
        check_eq("rst_rdata",   bus.rdata_o,        32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_awready", 32'(bus.awready_o), 32'd1);

        // RX push A,B,C then count / pop in order
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.rx_v_i = 1'b1;
            bus.rx_data_i = rx_vec[i];
        end
        @(negedge clk);
        bus.rx_v_i = 1'b0;
        axil_read(32'h1018, rd, rs);
        check_eq("rx_cnt3", rd, 32'd3);
        check_eq("rx_cnt3_resp", 32'(rs), 32'd0);
        for (int i = 0; i < 3; i++) begin
            axil_read(32'h101C, rd, rs);
            check_eq("rx_pop_data", rd, rx_vec[i]);
            check_eq("rx_pop_resp", 32'(rs), 32'd0);
        end
        axil_read(32'h1018, rd, rs);
        check_eq("rx_cnt0", rd, 32'd0);

        // pop from empty RX
        axil_read(32'h101C, rd, rs);
        check_eq("rx_empty_data", rd, 32'd0);
        check_eq("rx_empty_resp", 32'(rs), 32'd2);
        axil_read(32'h1018, rd, rs);
        check_eq("rx_empty_cnt", rd, 32'd0);

        // W three cycles ahead of AW
        @(negedge clk);
        bus.wdata_i = 32'h0000_DEAD;
        bus.wvalid_i = 1'b1;
        @(negedge clk);
        bus.wvalid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("w_held_wready", 32'(bus.wready_o), 32'd0);
        check_eq("w_held_bvalid", 32'(bus.bvalid_o), 32'd0);
        bus.awaddr_i = 32'h1000;
        bus.awvalid_i = 1'b1;
        @(negedge clk);
        bus.awvalid_i = 1'b0;
        check_eq("late_aw_bvalid", 32'(bus.bvalid_o), 32'd1);
        check_eq("late_aw_bresp",  32'(bus.bresp_o),  32'd0);
        check_eq("late_aw_tx_v",   32'(bus.tx_v_o),   32'd1);
        check_eq("late_aw_tx_data", bus.tx_data_o,    32'h0000_DEAD);
        @(negedge clk);
        check_eq("late_aw_bdone", 32'(bus.bvalid_o), 32'd0);
        bus.tx_yumi_i = 1'b1;
        @(negedge clk);
        bus.tx_yumi_i = 1'b0;
        check_eq("tx_drained", 32'(bus.tx_v_o), 32'd0);

        // fill TX to 16, overflow, drain in order
        axil_read(32'h1010, rd, rs);
        check_eq("tx_vac16", rd, 32'd16);
        for (int i = 0; i < 16; i++) begin
            axil_write(32'h1000, 32'h0000_0100 + 32'(i), rs);
            check_eq("tx_fill_resp", 32'(rs), 32'd0);
        end
        axil_read(32'h1010, rd, rs);
        check_eq("tx_vac0", rd, 32'd0);
        axil_write(32'h1000, 32'hFFFF_FFFF, rs);
        check_eq("tx_ovf_resp", 32'(rs), 32'd2);
        for (int i = 0; i < 16; i++) begin
            check_eq("tx_order_v", 32'(bus.tx_v_o), 32'd1);
            check_eq("tx_order_data", bus.tx_data_o, 32'h0000_0100 + 32'(i));
            bus.tx_yumi_i = 1'b1;
            @(negedge clk);
            bus.tx_yumi_i = 1'b0;
        end
        check_eq("tx_empty_after", 32'(bus.tx_v_o), 32'd0);

        // RX full with rx_v held across a pop
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.rx_v_i = 1'b1;
            bus.rx_data_i = 32'h0000_5000 + 32'(i);
        end
        @(negedge clk);
        bus.rx_data_i = 32'h0000_5AAA;
        bus.araddr_i = 32'h101C;
        bus.arvalid_i = 1'b1;
        check_eq("rx_full_ready", 32'(bus.rx_ready_o), 32'd0);
        @(negedge clk);
        bus.arvalid_i = 1'b0;
        check_eq("rx_after_pop_ready", 32'(bus.rx_ready_o), 32'd1);
        check_eq("rx_full_pop_v", 32'(bus.rvalid_o), 32'd1);
        check_eq("rx_full_pop_data", bus.rdata_o, 32'h0000_5000);
        @(negedge clk);
        bus.rx_v_i = 1'b0;
        check_eq("rx_refill_ready", 32'(bus.rx_ready_o), 32'd0);
        axil_read(32'h1018, rd, rs);
        check_eq("rx_refill_cnt", rd, 32'd16);
        for (int i = 1; i < 16; i++) begin
            axil_read(32'h101C, rd, rs);
            check_eq("rx_drain_data", rd, 32'h0000_5000 + 32'(i));
        end
        axil_read(32'h101C, rd, rs);
        check_eq("rx_drain_last", rd, 32'h0000_5AAA);

        // decode errors, held write response
        axil_read(32'h2000, rd, rs);
        check_eq("dec_rd_data", rd, 32'd0);
        check_eq("dec_rd_resp", 32'(rs), 32'd3);
        axil_read(32'h1000, rd, rs);
        check_eq("dec_rd_wo_resp", 32'(rs), 32'd3);
        @(negedge clk);
        bus.bready_i = 1'b0;
        bus.awaddr_i = 32'h1004;
        bus.awvalid_i = 1'b1;
        bus.wdata_i = 32'h1234_5678;
        bus.wvalid_i = 1'b1;
        @(negedge clk);
        bus.awvalid_i = 1'b0;
        bus.wvalid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("dec_wr_bvalid_held", 32'(bus.bvalid_o), 32'd1);
            check_eq("dec_wr_awready", 32'(bus.awready_o), 32'd0);
            check_eq("dec_wr_bresp", 32'(bus.bresp_o), 32'd3);
            @(negedge clk);
        end
        bus.bready_i = 1'b1;
        @(negedge clk);
        check_eq("dec_wr_bdone", 32'(bus.bvalid_o), 32'd0);
        check_eq("dec_tx_unchanged", 32'(bus.tx_v_o), 32'd0);
        axil_read(32'h1010, rd, rs);
        check_eq("dec_tx_vac", rd, 32'd16);
        axil_read(32'h1018, rd, rs);
        check_eq("dec_rx_cnt", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
